// File: rtl/addsub15_operand_sequencer.sv
// ---------------------------------------------------------------------------
// addsub15_operand_sequencer
//
// Sequencing stage wrapped around an external 15-bit carry-ripple
// adder/subtractor. A request is accepted over a valid/ready handshake and
// its operands are registered onto the adder inputs. The operands are held
// while the ripple settles, then S/V are captured into a result register
// that is presented over a second valid/ready handshake. An optional
// running accumulator can replace operand A and receive the result.
//
// Parameters:
//   SETTLE_CYCLES  clock edges operands are held before S/V are sampled
//                  (1..15). OUT_VALID rises this many edges after accept.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   IN_VALID/IN_READY   request handshake; IN_READY = FSM idle
//   IN_A, IN_B, IN_SUB  operands and add(0)/subtract(1) select
//   ACC_MODE            use ACC as operand A and write the result to ACC
//   ACC_CLR             clear ACC and ACC_OVF (any state, wins over update)
//   ADD_A/ADD_B/ADD_C0  registered drive to the adder (raw B, C0 = IN_SUB)
//   ADD_S/ADD_V         sum and overflow returned by the adder
//   OUT_VALID/OUT_READY result handshake
//   OUT_S, OUT_V        captured sum/difference and overflow
//   ACC, ACC_OVF        accumulator and its sticky overflow flag
// ---------------------------------------------------------------------------
module addsub15_operand_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [14:0] IN_A,
  input  logic [14:0] IN_B,
  input  logic        IN_SUB,
  input  logic        ACC_MODE,
  input  logic        ACC_CLR,
  output logic [14:0] ADD_A,
  output logic [14:0] ADD_B,
  output logic        ADD_C0,
  input  logic [14:0] ADD_S,
  input  logic        ADD_V,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [14:0] OUT_S,
  output logic        OUT_V,
  output logic [14:0] ACC,
  output logic        ACC_OVF
);

  // Counter is loaded with SETTLE_CYCLES-1 so capture happens on the
  // SETTLE_CYCLES-th edge after the accepting edge.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [14:0] add_a_q, add_a_d;
  logic [14:0] add_b_q, add_b_d;
  logic        add_c0_q, add_c0_d;
  logic        out_valid_q, out_valid_d;
  logic [14:0] out_s_q, out_s_d;
  logic        out_v_q, out_v_d;
  logic [14:0] acc_q, acc_d;
  logic        acc_ovf_q, acc_ovf_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mode_q      <= 1'b0;
      add_a_q     <= 15'd0;
      add_b_q     <= 15'd0;
      add_c0_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= 15'd0;
      out_v_q     <= 1'b0;
      acc_q       <= 15'd0;
      acc_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c0_q    <= add_c0_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_v_q     <= out_v_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_c0_d    = add_c0_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_v_d     = out_v_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          // acc_q here is the pre-clear value even if ACC_CLR is high.
          add_a_d  = ACC_MODE ? acc_q : IN_A;
          add_b_d  = IN_B;
          add_c0_d = IN_SUB;
          mode_d   = ACC_MODE;
          cnt_d    = SETTLE_INIT;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_s_d     = ADD_S;
          out_v_d     = ADD_V;
          out_valid_d = 1'b1;
          if (mode_q) begin
            acc_d     = ADD_S;
            acc_ovf_d = acc_ovf_q | ADD_V;
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear has priority over any accumulate update in the same cycle.
    if (ACC_CLR) begin
      acc_d     = 15'd0;
      acc_ovf_d = 1'b0;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign ADD_A     = add_a_q;
  assign ADD_B     = add_b_q;
  assign ADD_C0    = add_c0_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_S     = out_s_q;
  assign OUT_V     = out_v_q;
  assign ACC       = acc_q;
  assign ACC_OVF   = acc_ovf_q;

endmodule

// File: tb/tb_addsub15_operand_sequencer.sv
module tb_addsub15_operand_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID, IN_READY;
  logic [14:0] IN_A, IN_B;
  logic        IN_SUB, ACC_MODE, ACC_CLR;
  logic [14:0] ADD_A, ADD_B;
  logic        ADD_C0;
  logic [14:0] ADD_S;
  logic        ADD_V;
  logic        OUT_VALID, OUT_READY;
  logic [14:0] OUT_S;
  logic        OUT_V;
  logic [14:0] ACC;
  logic        ACC_OVF;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  // Behavioural model of the external ripple adder/subtractor.
  logic [14:0] b_eff;
  logic [15:0] sum_w;
  assign b_eff = ADD_B ^ {15{ADD_C0}};
  assign sum_w = {1'b0, ADD_A} + {1'b0, b_eff} + 16'(ADD_C0);
  assign ADD_S = sum_w[14:0];
  assign ADD_V = (ADD_A[14] == b_eff[14]) && (sum_w[14] != ADD_A[14]);

  addsub15_operand_sequencer #(.SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_SUB(IN_SUB),
    .ACC_MODE(ACC_MODE), .ACC_CLR(ACC_CLR),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C0(ADD_C0),
    .ADD_S(ADD_S), .ADD_V(ADD_V),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_S(OUT_S), .OUT_V(OUT_V),
    .ACC(ACC), .ACC_OVF(ACC_OVF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for exactly one accepting edge.
  task automatic req(input logic [14:0] a, input logic [14:0] b,
                     input logic sub, input logic mode);
    IN_A = a; IN_B = b; IN_SUB = sub; ACC_MODE = mode; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  // Bounded wait for OUT_VALID; an expired bound is a failed comparison.
  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (OUT_VALID !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_valid_timeout"}, 32'(OUT_VALID), 32'd1);
  endtask

  task automatic pop();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  logic [14:0] hs, ha;

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_SUB = 1'b0;
    ACC_MODE = 1'b0; ACC_CLR = 1'b0; OUT_READY = 1'b0;
    #12;
    // Reset state
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_add_a", 32'(ADD_A), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_acc", 32'(ACC), 32'd0);
    chk("rst_acc_ovf", 32'(ACC_OVF), 32'd0);
    RST_N = 1'b1;
    tick();

    // Plain add, exact latency
    req(15'h0005, 15'h0003, 1'b0, 1'b0);
    chk("add_in_ready_low", 32'(IN_READY), 32'd0);
    chk("add_add_a", 32'(ADD_A), 32'h5);
    chk("add_add_b", 32'(ADD_B), 32'h3);
    chk("add_c0", 32'(ADD_C0), 32'd0);
    chk("add_valid_edge0", 32'(OUT_VALID), 32'd0);
    tick();
    chk("add_valid_edge1", 32'(OUT_VALID), 32'd0);
    tick();
    chk("add_valid_edge2", 32'(OUT_VALID), 32'd1);
    chk("add_out_s", 32'(OUT_S), 32'h8);
    chk("add_out_v", 32'(OUT_V), 32'd0);
    chk("add_in_ready_hold", 32'(IN_READY), 32'd0);
    pop();
    chk("add_valid_drop", 32'(OUT_VALID), 32'd0);
    chk("add_in_ready_back", 32'(IN_READY), 32'd1);

    // Subtract with overflow
    req(15'h4000, 15'h2004, 1'b1, 1'b0);
    chk("sub_c0", 32'(ADD_C0), 32'd1);
    wait_valid("sub");
    chk("sub_out_s", 32'(OUT_S), 32'h1FFC);
    chk("sub_out_v", 32'(OUT_V), 32'd1);
    pop();

    // Accumulate twice from a cleared ACC
    ACC_CLR = 1'b1; tick(); ACC_CLR = 1'b0;
    chk("clr_acc", 32'(ACC), 32'd0);
    req(15'h1111, 15'h3FFF, 1'b0, 1'b1);
    chk("acc1_add_a", 32'(ADD_A), 32'd0);
    wait_valid("acc1");
    chk("acc1_acc", 32'(ACC), 32'h3FFF);
    chk("acc1_ovf", 32'(ACC_OVF), 32'd0);
    pop();
    req(15'h1111, 15'h3FFF, 1'b0, 1'b1);
    chk("acc2_add_a", 32'(ADD_A), 32'h3FFF);
    wait_valid("acc2");
    chk("acc2_acc", 32'(ACC), 32'h7FFE);
    chk("acc2_out_v", 32'(OUT_V), 32'd1);
    chk("acc2_ovf", 32'(ACC_OVF), 32'd1);
    pop();

    // Backpressure: result and operands frozen, new requests ignored
    req(15'h1234, 15'h0111, 1'b0, 1'b0);
    wait_valid("bp");
    hs = OUT_S; ha = ADD_A;
    chk("bp_out_s", 32'(hs), 32'h1345);
    for (int i = 0; i < 5; i++) begin
      IN_VALID = i[0]; IN_A = 15'h7777; IN_B = 15'h0001;
      tick();
      chk("bp_hold_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_hold_s", 32'(OUT_S), 32'h1345);
      chk("bp_hold_add_a", 32'(ADD_A), 32'h1234);
      chk("bp_in_ready", 32'(IN_READY), 32'd0);
    end
    IN_VALID = 1'b0;
    pop();
    chk("bp_ready_after", 32'(IN_READY), 32'd1);
    req(15'h0042, 15'h0001, 1'b0, 1'b0);
    chk("bp_resume_add_a", 32'(ADD_A), 32'h0042);
    wait_valid("bp2");
    pop();

    // Reset mid-DRIVE: ACC is 0x7FFE, aborted accumulate must not land
    req(15'h0000, 15'h0001, 1'b0, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_add_a", 32'(ADD_A), 32'd0);
    chk("mrst_acc", 32'(ACC), 32'd0);
    chk("mrst_ovf", 32'(ACC_OVF), 32'd0);
    chk("mrst_in_ready", 32'(IN_READY), 32'd1);
    RST_N = 1'b1;
    tick(); tick();
    chk("mrst_valid_after", 32'(OUT_VALID), 32'd0);
    chk("mrst_ready_after", 32'(IN_READY), 32'd1);

    // Build ACC = 0x0010, then clear coincident with an ACC_MODE accept
    req(15'h0000, 15'h0010, 1'b0, 1'b1);
    wait_valid("pre");
    pop();
    chk("pre_acc", 32'(ACC), 32'h10);
    ACC_CLR = 1'b1;
    req(15'h0000, 15'h0100, 1'b0, 1'b1);
    ACC_CLR = 1'b0;
    chk("clracc_add_a", 32'(ADD_A), 32'h10);
    chk("clracc_acc", 32'(ACC), 32'd0);
    wait_valid("clracc");
    chk("clracc_result_acc", 32'(ACC), 32'h0110);
    pop();

    // Clear coincident with the capture edge
    req(15'h0000, 15'h0005, 1'b0, 1'b1);
    tick();                 // counter 1 -> 0; next edge captures
    ACC_CLR = 1'b1;
    tick();
    ACC_CLR = 1'b0;
    chk("clrcap_valid", 32'(OUT_VALID), 32'd1);
    chk("clrcap_out_s", 32'(OUT_S), 32'h0115);
    chk("clrcap_acc", 32'(ACC), 32'd0);
    chk("clrcap_ovf", 32'(ACC_OVF), 32'd0);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub15_operand_sequencer.md
Name: addsub15_operand_sequencer

Overview:
Sequential front/back stage for the 15-bit carry-ripple adder/subtractor. It accepts operand requests over a valid/ready handshake and drives registered A, B and C0 into the combinational adder. It waits a fixed settle interval for ripple propagation, then captures S and V into a result register with its own valid/ready handshake. It also maintains an optional running accumulator fed back as operand A.

Parameters:
SETTLE_CYCLES, 2, number of clock edges operands are held before S/V are sampled; legal range 1..15.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
IN_VALID  in  1  request valid.
IN_READY  out  1  sequencer can accept a request.
IN_A  in  15  operand A, two's complement.
IN_B  in  15  operand B, two's complement.
IN_SUB  in  1  1 = A-B, 0 = A+B.
ACC_MODE  in  1  1 = use ACC as operand A and write the result back to ACC.
ACC_CLR  in  1  synchronous clear of ACC and ACC_OVF.
ADD_A  out  15  to adder A0..A14.
ADD_B  out  15  to adder B0..B14; raw B, the adder inverts internally.
ADD_C0  out  1  to adder C0 (add/subtract select and carry-in).
ADD_S  in  15  from adder S0..S14.
ADD_V  in  1  from adder overflow V.
OUT_VALID  out  1  result valid.
OUT_READY  in  1  consumer accepts the result.
OUT_S  out  15  captured sum/difference.
OUT_V  out  1  captured overflow.
ACC  out  15  accumulator value.
ACC_OVF  out  1  sticky overflow, set by any accumulate that produced V=1.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; ADD_A/ADD_B=0, ADD_C0=0; OUT_VALID=0, OUT_S=0, OUT_V=0; ACC=0, ACC_OVF=0; settle counter=0.
- IN_READY = (state==IDLE). It is combinational from state only and is 1 immediately after reset.
- The FSM has three states: IDLE, DRIVE and HOLD.
- IDLE, on IN_VALID & IN_READY at the clock edge:
  - ADD_A <= ACC_MODE ? ACC : IN_A.
  - ADD_B <= IN_B; ADD_C0 <= IN_SUB.
  - Latch ACC_MODE internally; load the counter with SETTLE_CYCLES-1; go to DRIVE.
  - With no request, the FSM stays in IDLE and the operand registers hold their last values.
- DRIVE:
  - ADD_A, ADD_B and ADD_C0 are stable throughout.
  - When counter != 0, decrement it.
  - When counter == 0, at the edge: OUT_S <= ADD_S, OUT_V <= ADD_V, OUT_VALID <= 1.
  - If the latched mode is 1, also ACC <= ADD_S and ACC_OVF <= ACC_OVF | ADD_V. Then go to HOLD.
  - Latency: OUT_VALID rises exactly SETTLE_CYCLES edges after the accepting edge.
- HOLD:
  - OUT_VALID=1; OUT_S, OUT_V and the adder operands stay stable until OUT_READY=1 at an edge.
  - On that edge: OUT_VALID <= 0 and go to IDLE.
  - A new request cannot be accepted in that same cycle, so there is a minimum one-cycle bubble. Sustained throughput is one result per SETTLE_CYCLES+2 cycles.
- ACC_CLR:
  - Acts in any state: ACC <= 0, ACC_OVF <= 0.
  - If coincident with an accumulate capture, the clear wins.
  - If coincident with an accept in ACC_MODE, ADD_A takes the pre-clear ACC.
- Arithmetic: all 15-bit values are two's complement. Wrap-around is modulo 2^15. No saturation is applied; V is taken only from the adder.
- Input changes while not in IDLE are ignored. Handshake signals must be free of X once reset is released.
- Reset mid-operation aborts immediately to the reset values. Any pending result and any in-flight accumulate are lost.

Test Plan:
- Plain add: IN_A=0x0005, IN_B=0x0003, IN_SUB=0, SETTLE_CYCLES=2 -> OUT_VALID 2 edges after accept; OUT_S=0x0008, OUT_V=0; IN_READY low until the OUT handshake.
- Subtract with overflow: IN_A=0x4000, IN_B=0x2004, IN_SUB=1 -> ADD_C0=1, OUT_S=0x1FFC, OUT_V=1.
- Accumulate: ACC_CLR, then two ACC_MODE requests with IN_B=0x3FFF, IN_SUB=0 -> ACC=0x3FFF with ACC_OVF=0, then ACC=0x7FFE with OUT_V=1 and ACC_OVF=1.
- Backpressure: OUT_READY held 0 for 5 cycles in HOLD -> OUT_S, OUT_V, OUT_VALID and the ADD_* outputs constant; IN_VALID pulses ignored; acceptance resumes the cycle after OUT_READY.
- Reset mid-DRIVE: assert RST_N=0 between accept and capture -> all outputs 0 asynchronously, ACC unchanged by the aborted op (0 after reset), IN_READY=1 after release.
- Clear collision: ACC_CLR asserted on the ACC_MODE capture edge -> ACC=0, ACC_OVF=0, OUT_S still holds the sum.
